// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access size codes
// and the default ack timeout.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side request/response and memory-side bus of the data-memory controller.
// Handshake: a request transfers on a rising edge where req_valid_in & req_ready_out;
// the memory transfer completes on the edge where dm_req_out & dm_ack_in.
interface dmem_access_ctrl_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_is_store_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        dm_req_out;
  logic        dm_wr_out;
  logic [31:0] dm_addr_out;
  logic [31:0] dm_wdata_out;
  logic [3:0]  dm_wmask_out;
  logic        dm_ack_in;
  logic [31:0] dm_rdata_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_byte_sel_out;
  logic [1:0]  rsp_load_size_out;
  logic        rsp_load_unsigned_out;
  logic        misaligned_out;
  logic        timeout_out;
  logic        stall_out;

  modport slave (
    input  req_valid_in, req_is_store_in, req_funct3_in, req_addr_in, req_wdata_in,
           dm_ack_in, dm_rdata_in,
    output req_ready_out, dm_req_out, dm_wr_out, dm_addr_out, dm_wdata_out, dm_wmask_out,
           rsp_valid_out, rsp_rdata_out, rsp_byte_sel_out, rsp_load_size_out,
           rsp_load_unsigned_out, misaligned_out, timeout_out, stall_out
  );

  modport master (
    output req_valid_in, req_is_store_in, req_funct3_in, req_addr_in, req_wdata_in,
           dm_ack_in, dm_rdata_in,
    input  req_ready_out, dm_req_out, dm_wr_out, dm_addr_out, dm_wdata_out, dm_wmask_out,
           rsp_valid_out, rsp_rdata_out, rsp_byte_sel_out, rsp_load_size_out,
           rsp_load_unsigned_out, misaligned_out, timeout_out, stall_out
  );
endinterface

// File: rtl/dmem_lane_gen.sv
// Combinational byte-lane steering: store write mask, lane-replicated store data
// and the alignment/illegal-encoding error flag.
module dmem_lane_gen
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    wmask      = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (funct3[1:0])
      SIZE_BYTE: begin
        wmask     = 4'b0001 << byte_sel;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        wmask      = byte_sel[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = byte_sel[0];
      end
      SIZE_WORD: begin
        wmask      = 4'b1111;
        misaligned = (byte_sel != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
    // Unsigned stores have no meaning; treat them like an illegal size.
    if (is_store && funct3[2]) misaligned = 1'b1;
    if (!is_store) wmask = 4'b0000;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one load/store at a time, drives the
// memory bus until ack or timeout, and returns a one-cycle response.
module dmem_access_ctrl
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  dmem_access_ctrl_if.slave bus,
  output state_t            state_dbg
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_next;
  logic        ready_q;
  logic        accept;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic        lane_err;

  dmem_lane_gen u_lane_gen (
    .byte_sel   (bus.req_addr_in[1:0]),
    .funct3     (bus.req_funct3_in),
    .is_store   (bus.req_is_store_in),
    .wdata      (bus.req_wdata_in),
    .wmask      (lane_wmask),
    .wdata_rep  (lane_wdata),
    .misaligned (lane_err)
  );

  assign accept        = bus.req_valid_in & ready_q;
  assign cnt_next      = cnt_q + 8'd1;
  assign bus.req_ready_out = ready_q;
  // ready_q is low in reset, so stall also reads 0 while reset is held.
  assign bus.stall_out = ((state_q == ST_IDLE) & bus.req_valid_in & ready_q) |
                         (state_q == ST_ACCESS);
  assign state_dbg     = state_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q                   <= ST_IDLE;
      cnt_q                     <= 8'd0;
      ready_q                   <= 1'b0;
      bus.dm_req_out            <= 1'b0;
      bus.dm_wr_out             <= 1'b0;
      bus.dm_addr_out           <= 32'd0;
      bus.dm_wdata_out          <= 32'd0;
      bus.dm_wmask_out          <= 4'd0;
      bus.rsp_valid_out         <= 1'b0;
      bus.rsp_rdata_out         <= 32'd0;
      bus.rsp_byte_sel_out      <= 2'd0;
      bus.rsp_load_size_out     <= 2'd0;
      bus.rsp_load_unsigned_out <= 1'b0;
      bus.misaligned_out        <= 1'b0;
      bus.timeout_out           <= 1'b0;
    end else begin
      bus.rsp_valid_out  <= 1'b0;
      bus.misaligned_out <= 1'b0;
      bus.timeout_out    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q                   <= 1'b0;
            bus.rsp_byte_sel_out      <= bus.req_addr_in[1:0];
            bus.rsp_load_size_out     <= bus.req_funct3_in[1:0];
            bus.rsp_load_unsigned_out <= bus.req_funct3_in[2];
            if (lane_err) begin
              state_q            <= ST_ERR;
              bus.rsp_valid_out  <= 1'b1;
              bus.misaligned_out <= 1'b1;
            end else begin
              state_q          <= ST_ACCESS;
              cnt_q            <= 8'd0;
              bus.dm_req_out   <= 1'b1;
              bus.dm_wr_out    <= bus.req_is_store_in;
              bus.dm_addr_out  <= {bus.req_addr_in[31:2], 2'b00};
              bus.dm_wdata_out <= lane_wdata;
              bus.dm_wmask_out <= lane_wmask;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (bus.dm_ack_in) begin
            state_q            <= ST_RESP;
            bus.dm_req_out     <= 1'b0;
            bus.rsp_valid_out  <= 1'b1;
            bus.rsp_rdata_out  <= bus.dm_wr_out ? 32'd0 : bus.dm_rdata_in;
          end else if (cnt_next == TMO) begin
            state_q           <= ST_ERR;
            cnt_q             <= cnt_next;
            bus.dm_req_out    <= 1'b0;
            bus.rsp_valid_out <= 1'b1;
            bus.timeout_out   <= 1'b1;
          end else begin
            cnt_q <= cnt_next;
          end
        end
        ST_RESP, ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 4-cycle ack timeout.
module tb_dmem_access_ctrl;
  import riscv_lsu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     total;
  int     bad;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid_in    = 1'b1;
    bus.req_is_store_in = st;
    bus.req_funct3_in   = f3;
    bus.req_addr_in     = addr;
    bus.req_wdata_in    = wd;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid_in    = 1'b0;
    bus.req_is_store_in = 1'b0;
    bus.req_funct3_in   = 3'd0;
    bus.req_addr_in     = 32'd0;
    bus.req_wdata_in    = 32'd0;
    bus.dm_ack_in       = 1'b0;
    bus.dm_rdata_in     = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready_out), 32'd0);
    chk("rst_dm_req", 32'(bus.dm_req_out), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(bus.req_ready_out), 32'd1);
    chk("idle_stall", 32'(bus.stall_out), 32'd0);

    // Load word 0x1004, ack at T+1
    drive_req(1'b0, 3'b010, 32'h0000_1004, 32'd0);
    #1;
    chk("lw_stall_idle", 32'(bus.stall_out), 32'd1);
    tick();
    bus.req_valid_in = 1'b0;
    chk("lw_dm_req", 32'(bus.dm_req_out), 32'd1);
    chk("lw_dm_addr", bus.dm_addr_out, 32'h0000_1004);
    chk("lw_mask", 32'(bus.dm_wmask_out), 32'h0);
    chk("lw_wr", 32'(bus.dm_wr_out), 32'd0);
    chk("lw_ready_busy", 32'(bus.req_ready_out), 32'd0);
    chk("lw_stall_acc", 32'(bus.stall_out), 32'd1);
    bus.dm_ack_in   = 1'b1;
    bus.dm_rdata_in = 32'hDEAD_BEEF;
    tick();
    bus.dm_ack_in = 1'b0;
    chk("lw_rsp_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("lw_rsp_rdata", bus.rsp_rdata_out, 32'hDEAD_BEEF);
    chk("lw_byte_sel", 32'(bus.rsp_byte_sel_out), 32'd0);
    chk("lw_size", 32'(bus.rsp_load_size_out), 32'd2);
    chk("lw_dm_req_drop", 32'(bus.dm_req_out), 32'd0);
    chk("lw_stall_resp", 32'(bus.stall_out), 32'd0);
    tick();
    chk("lw_rsp_pulse", 32'(bus.rsp_valid_out), 32'd0);
    chk("lw_ready_again", 32'(bus.req_ready_out), 32'd1);

    // Store byte 0xA5 at 0x2003, ack one cycle late
    drive_req(1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5);
    tick();
    bus.req_valid_in = 1'b0;
    chk("sb_mask", 32'(bus.dm_wmask_out), 32'h8);
    chk("sb_wdata", bus.dm_wdata_out, 32'hA5A5_A5A5);
    chk("sb_addr", bus.dm_addr_out, 32'h0000_2000);
    chk("sb_wr", 32'(bus.dm_wr_out), 32'd1);
    tick();
    chk("sb_hold_req", 32'(bus.dm_req_out), 32'd1);
    chk("sb_hold_mask", 32'(bus.dm_wmask_out), 32'h8);
    chk("sb_no_rsp", 32'(bus.rsp_valid_out), 32'd0);
    bus.dm_ack_in   = 1'b1;
    bus.dm_rdata_in = 32'h1234_5678;
    tick();
    bus.dm_ack_in = 1'b0;
    chk("sb_rsp_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("sb_rsp_rdata", bus.rsp_rdata_out, 32'h0);
    chk("sb_byte_sel", 32'(bus.rsp_byte_sel_out), 32'd3);
    tick();

    // Store half at 0x3002
    drive_req(1'b1, 3'b001, 32'h0000_3002, 32'h1234_BEEF);
    tick();
    bus.req_valid_in = 1'b0;
    chk("sh_mask", 32'(bus.dm_wmask_out), 32'hC);
    chk("sh_wdata", bus.dm_wdata_out, 32'hBEEF_BEEF);
    bus.dm_ack_in = 1'b1;
    tick();
    bus.dm_ack_in = 1'b0;
    chk("sh_rsp_valid", 32'(bus.rsp_valid_out), 32'd1);
    tick();

    // Misaligned load half at 0x0001
    drive_req(1'b0, 3'b001, 32'h0000_0001, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("mh_misaligned", 32'(bus.misaligned_out), 32'd1);
    chk("mh_rsp_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("mh_no_dm_req", 32'(bus.dm_req_out), 32'd0);
    chk("mh_timeout", 32'(bus.timeout_out), 32'd0);
    chk("mh_byte_sel", 32'(bus.rsp_byte_sel_out), 32'd1);
    chk("mh_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk("mh_pulse", 32'(bus.misaligned_out), 32'd0);
    chk("mh_ready", 32'(bus.req_ready_out), 32'd1);

    // Illegal size and unsigned store
    drive_req(1'b0, 3'b011, 32'h0000_0000, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("ill_size", 32'(bus.misaligned_out), 32'd1);
    tick();
    drive_req(1'b1, 3'b100, 32'h0000_0000, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("ill_ustore", 32'(bus.misaligned_out), 32'd1);
    tick();
    drive_req(1'b0, 3'b010, 32'h0000_0002, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("mis_word", 32'(bus.misaligned_out), 32'd1);
    tick();

    // Timeout after 4 ACCESS cycles, late ack ignored
    drive_req(1'b0, 3'b010, 32'h0000_4000, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_c%0d", i), 32'(bus.dm_req_out), 32'd1);
      tick();
    end
    chk("to_pulse", 32'(bus.timeout_out), 32'd1);
    chk("to_rsp_valid", 32'(bus.rsp_valid_out), 32'd1);
    chk("to_dm_req", 32'(bus.dm_req_out), 32'd0);
    chk("to_mis", 32'(bus.misaligned_out), 32'd0);
    bus.dm_ack_in   = 1'b1;
    bus.dm_rdata_in = 32'h5555_AAAA;
    tick();
    chk("late_ack_rsp", 32'(bus.rsp_valid_out), 32'd0);
    chk("late_ack_to", 32'(bus.timeout_out), 32'd0);
    tick();
    bus.dm_ack_in = 1'b0;
    chk("idle_ack_rsp", 32'(bus.rsp_valid_out), 32'd0);
    chk("idle_ack_state", 32'(state_dbg), 32'(ST_IDLE));

    // Ack on the 4th ACCESS cycle wins over timeout
    drive_req(1'b0, 3'b010, 32'h0000_4800, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("edge_req", 32'(bus.dm_req_out), 32'd1);
    bus.dm_ack_in   = 1'b1;
    bus.dm_rdata_in = 32'h1122_3344;
    tick();
    bus.dm_ack_in = 1'b0;
    chk("edge_rsp", 32'(bus.rsp_valid_out), 32'd1);
    chk("edge_no_to", 32'(bus.timeout_out), 32'd0);
    chk("edge_rdata", bus.rsp_rdata_out, 32'h1122_3344);
    tick();

    // Reset mid-ACCESS with no ack yet
    drive_req(1'b0, 3'b010, 32'h0000_5000, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("rm_req", 32'(bus.dm_req_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_req_async", 32'(bus.dm_req_out), 32'd0);
    chk("rm_stall", 32'(bus.stall_out), 32'd0);
    chk("rm_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rm_addr", bus.dm_addr_out, 32'd0);
    tick();
    chk("rm_no_rsp", 32'(bus.rsp_valid_out), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rm_no_rsp2", 32'(bus.rsp_valid_out), 32'd0);
    chk("rm_ready", 32'(bus.req_ready_out), 32'd1);

    // Fresh unsigned byte load after reset
    drive_req(1'b0, 3'b100, 32'h0000_6002, 32'd0);
    tick();
    bus.req_valid_in = 1'b0;
    chk("lbu_addr", bus.dm_addr_out, 32'h0000_6000);
    bus.dm_ack_in   = 1'b1;
    bus.dm_rdata_in = 32'hCAFE_F00D;
    tick();
    bus.dm_ack_in = 1'b0;
    chk("lbu_rsp", 32'(bus.rsp_valid_out), 32'd1);
    chk("lbu_rdata", bus.rsp_rdata_out, 32'hCAFE_F00D);
    chk("lbu_sel", 32'(bus.rsp_byte_sel_out), 32'd2);
    chk("lbu_size", 32'(bus.rsp_load_size_out), 32'd0);
    chk("lbu_uns", 32'(bus.rsp_load_unsigned_out), 32'd1);
    tick();
    chk("lbu_hold_rdata", bus.rsp_rdata_out, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
